// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: op codes, error codes and
// the sequencer FSM state encoding.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;
    localparam logic [3:0] OP_MOD = 4'd4;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;
    localparam logic [1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   start        load magnitudes (a_mag, b_mag) and select mode
//   mode         0 = multiply, 1 = divide (sampled on start)
//   step         advance one iteration
//   a_mag/b_mag  multiplicand/multiplier, or dividend/divisor magnitudes
//   last         the step now pending is the final one
//   acc          MUL: product; DIV: quotient in the low half
//   rem          DIV: remainder
module seq_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    input  logic               step,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    output logic               last,
    output logic [2*WIDTH-1:0] acc,
    output logic [WIDTH-1:0]   rem
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] opd;     // multiplicand (MUL) or divisor (DIV)
    logic [CW-1:0]    cnt;     // iterations completed
    logic             mode_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;   // bit WIDTH set means the trial subtraction borrowed

    // Product register holds {partial_hi, remaining multiplier bits}.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] hi;
        hi = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {hi, p[WIDTH-1:1]};
    endfunction

    always_comb begin
        shifted = {rem, acc[WIDTH-1]};
        trial   = shifted - {1'b0, opd};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opd    <= '0;
            cnt    <= '0;
            mode_q <= 1'b0;
            acc    <= '0;
            rem    <= '0;
        end else if (start) begin
            opd    <= mode ? b_mag : a_mag;
            mode_q <= mode;
            rem    <= '0;
            if (mode) begin
                acc <= {{WIDTH{1'b0}}, a_mag};
                cnt <= '0;
            end else begin
                // The first partial product is only a select, so it is folded
                // into the load; the divider keeps its subtract off the input path.
                acc <= mul_step({{WIDTH{1'b0}}, b_mag}, a_mag);
                cnt <= CW'(1);
            end
        end else if (step) begin
            if (cnt != '1)
                cnt <= cnt + CW'(1);
            if (mode_q) begin
                rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
                acc <= mul_step(acc, opd);
            end
        end
    end

    assign last = (cnt == CW'(WIDTH-1));
endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked front end for the integer ALU: ADD/SUB in one cycle,
// MUL/DIV/MOD iteratively through seq_muldiv_core, sign fix-up in FIX.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   op_code, input1/2      operation and signed operands
//   rsp_valid/rsp_ready    response handshake
//   output1, err_code      signed 2*WIDTH result and error code
//   busy                   iterative op in progress (CALC or FIX)
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         op_code,
    input  logic [WIDTH-1:0]   input1,
    input  logic [WIDTH-1:0]   input2,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] output1,
    output logic [1:0]         err_code,
    output logic               busy
);
    state_t             state, state_nx;
    logic [3:0]         op_q;
    logic               sa_q, sb_q;
    logic               accept, core_start, core_mode, core_last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     as_sum;
    logic [2*WIDTH-1:0] acc, quot, rem_w, fix_res;
    logic [WIDTH-1:0]   rem;

    assign accept     = cmd_valid & cmd_ready;
    assign a_mag      = input1[WIDTH-1] ? WIDTH'(-input1) : input1;
    assign b_mag      = input2[WIDTH-1] ? WIDTH'(-input2) : input2;
    assign core_mode  = (op_code != OP_MUL);
    assign core_start = accept && ((op_code == OP_MUL) ||
                        ((op_code == OP_DIV || op_code == OP_MOD) && input2 != '0));
    // 17-bit exact sum/difference of the sign-extended operands
    assign as_sum     = (op_code == OP_SUB) ? {input1[WIDTH-1], input1} - {input2[WIDTH-1], input2}
                                            : {input1[WIDTH-1], input1} + {input2[WIDTH-1], input2};

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .mode  (core_mode),
        .step  (state == ST_CALC),
        .a_mag (a_mag),
        .b_mag (b_mag),
        .last  (core_last),
        .acc   (acc),
        .rem   (rem)
    );

    // Quotient sign follows the operand signs, remainder follows the dividend.
    assign quot  = {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
    assign rem_w = {{WIDTH{1'b0}}, rem};
    always_comb begin
        fix_res = '0;
        if (op_q == OP_MUL)
            fix_res = (sa_q ^ sb_q) ? -acc : acc;
        else if (op_q == OP_DIV)
            fix_res = (sa_q ^ sb_q) ? -quot : quot;
        else
            fix_res = sa_q ? -rem_w : rem_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (accept)
                    state_nx = core_start ? ST_CALC : ST_DONE;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (core_last)
                    state_nx = ST_FIX;
            end
            ST_FIX: begin
                busy     = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            output1  <= '0;
            err_code <= ERR_OK;
        end else if (accept) begin
            op_q <= op_code;
            sa_q <= input1[WIDTH-1];
            sb_q <= input2[WIDTH-1];
            case (op_code)
                OP_ADD, OP_SUB: begin
                    output1  <= {{(WIDTH-1){as_sum[WIDTH]}}, as_sum};
                    err_code <= (as_sum[WIDTH] != as_sum[WIDTH-1]) ? ERR_OVF : ERR_OK;
                end
                OP_MUL: begin
                    output1  <= '0;
                    err_code <= ERR_OK;
                end
                OP_DIV, OP_MOD: begin
                    output1  <= '0;
                    err_code <= (input2 == '0) ? ERR_DIV0 : ERR_OK;
                end
                default: begin
                    output1  <= '0;
                    err_code <= ERR_ILL;
                end
            endcase
        end else if (state == ST_FIX) begin
            output1 <= fix_res;
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  op_code = '0;
    logic [15:0] input1 = '0;
    logic [15:0] input2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] output1;
    logic [1:0]  err_code;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    alu_op_sequencer #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .op_code   (op_code),
        .input1    (input1),
        .input2    (input2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .output1   (output1),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: plain signed arithmetic plus the specified latencies.
    function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [31:0] res, output logic [1:0] err, output int lat);
        longint x, y, r;
        x = longint'($signed(a));
        y = longint'($signed(b));
        r = 0;
        err = 2'd0;
        lat = 1;
        case (op)
            4'd0: begin r = x + y; if (r > 32767 || r < -32768) err = 2'd1; end
            4'd1: begin r = x - y; if (r > 32767 || r < -32768) err = 2'd1; end
            4'd2: begin r = x * y; lat = 17; end
            4'd3: if (y == 0) err = 2'd2; else begin r = x / y; lat = 18; end
            4'd4: if (y == 0) err = 2'd2; else begin r = x % y; lat = 18; end
            default: err = 2'd3;
        endcase
        res = r[31:0];
    endfunction

    // Model of the transaction in flight, advanced on the clock.
    logic        m_busy = 1'b0;
    int          m_cyc = 0;
    int          m_lat = 1;
    logic [31:0] m_res = '0;
    logic [1:0]  m_err = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                model(op_code, input1, input2, m_res, m_err, m_lat);
                m_busy = 1'b1;
                m_cyc  = 1;
            end
        end else if (m_cyc >= m_lat && rsp_ready) begin
            m_busy = 1'b0;
        end else begin
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cmd_ready", cmd_ready, 1);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_output1", output1, 0);
            chk("rst_err", err_code, 0);
        end else begin
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("rsp_valid", rsp_valid, m_busy && m_cyc >= m_lat);
            chk("busy", busy, m_busy && m_lat > 1 && m_cyc < m_lat);
            if (m_busy && m_cyc >= m_lat) begin
                chk("output1", output1, m_res);
                chk("err_code", err_code, m_err);
            end
        end
    end

    // Issue one command from idle, wait (bounded) for the response, hold it, then take it.
    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold, output logic [31:0] res, output logic [1:0] err,
                        output int lat);
        @(negedge clk);
        cmd_valid = 1'b1; op_code = op; input1 = a; input2 = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (rsp_valid) begin lat = k; break; end
        end
        if (lat == 0) chk("rsp_timeout", 0, 1);
        res = output1;
        err = err_code;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_output1", output1, res);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic directed(input string name, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [31:0] eres, input logic [1:0] eerr,
                            input int elat);
        logic [31:0] r; logic [1:0] e; int l;
        model(op, a, b, r, e, l);
        chk({name, "_model_res"}, r, eres);
        chk({name, "_model_err"}, e, eerr);
        send(op, a, b, 0, r, e, l);
        chk({name, "_res"}, r, eres);
        chk({name, "_err"}, e, eerr);
        chk({name, "_lat"}, l, elat);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7fff;
            3: return 16'hffff;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] r; logic [1:0] e; int l; int sel; logic seen;
        logic [3:0] op;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_output1", output1, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;

        directed("add", OP_ADD, 16'd11, 16'd15, 32'd26, ERR_OK, 1);
        directed("sub", OP_SUB, 16'd11, 16'd15, -32'sd4, ERR_OK, 1);
        directed("mul_big", OP_MUL, 16'd32000, 16'd16000, 32'd512000000, ERR_OK, 17);
        directed("mul_neg", OP_MUL, -16'sd3, 16'd7, -32'sd21, ERR_OK, 17);
        directed("div", OP_DIV, 16'd32000, 16'd16000, 32'd2, ERR_OK, 18);
        directed("mod", OP_MOD, 16'd32000, 16'd16000, 32'd0, ERR_OK, 18);
        directed("div_neg", OP_DIV, -16'sd7, 16'd2, -32'sd3, ERR_OK, 18);
        directed("mod_neg", OP_MOD, -16'sd7, 16'd2, -32'sd1, ERR_OK, 18);
        directed("div_min", OP_DIV, 16'h8000, 16'hffff, 32'd32768, ERR_OK, 18);
        directed("div0", OP_DIV, 16'd11, 16'd0, 32'd0, ERR_DIV0, 1);
        directed("mod0", OP_MOD, 16'd11, 16'd0, 32'd0, ERR_DIV0, 1);
        directed("illegal", 4'b1001, 16'd5, 16'd6, 32'd0, ERR_ILL, 1);

        // Overflowing ADD held for 5 cycles with a second command waiting.
        @(negedge clk);
        cmd_valid = 1'b1; op_code = OP_ADD; input1 = 16'd32767; input2 = 16'd1;
        @(posedge clk);
        @(negedge clk);
        op_code = OP_ADD; input1 = 16'd1; input2 = 16'd2;
        chk("ovf_res", output1, 32'd32768);
        chk("ovf_err", err_code, ERR_OVF);
        repeat (5) begin
            @(negedge clk);
            chk("ovf_hold_res", output1, 32'd32768);
            chk("ovf_hold_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_hs_ready", cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("second_accepted", cmd_ready, 0);
        chk("second_res", output1, 32'd3);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset in the middle of a multiply.
        @(negedge clk);
        cmd_valid = 1'b1; op_code = OP_MUL; input1 = 16'd300; input2 = 16'd200;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        chk("midrst_output1", output1, 0);
        chk("midrst_err", err_code, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", seen, 0);
        directed("add_after_rst", OP_ADD, 16'd1, 16'd2, 32'd3, ERR_OK, 1);

        // Random commands, checked per cycle by the model.
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            op = (sel < 9) ? 4'(sel % 5) : 4'($urandom_range(5, 15));
            send(op, pick(), pick(), $urandom_range(0, 3), r, e, l);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
